mqnic_lfc_tx_ctrl: RTL and testbench

MQNIC_LFC_TX_CTRL -- requirements
Module: mqnic_lfc_tx_ctrl

---
 rtl/mqnic_lfc_tx_ctrl.sv | 135 +++++++++++++
 tb/tb_mqnic_lfc_tx_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mqnic_lfc_tx_ctrl.sv
// Link-level flow control transmit controller: turns a receive-congestion level
// into 802.3x PAUSE (XOFF/XON) MAC control frame requests with periodic XOFF refresh.
`timescale 1ns/1ps

module mqnic_lfc_tx_ctrl #(
  parameter int unsigned MCF_PARAMS_SIZE = 18,
  parameter int unsigned REFRESH_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         cfg_enable,
  input  logic [47:0]                  cfg_eth_src,
  input  logic [15:0]                  cfg_quanta,
  input  logic [REFRESH_WIDTH-1:0]     cfg_refresh,

  input  logic                         xoff_req,

  output logic                         mcf_valid,
  input  logic                         mcf_ready,
  output logic [47:0]                  mcf_eth_dst,
  output logic [47:0]                  mcf_eth_src,
  output logic [15:0]                  mcf_eth_type,
  output logic [15:0]                  mcf_opcode,
  output logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,

  output logic                         tx_paused,
  output logic                         stat_tx_xoff,
  output logic                         stat_tx_xon
);

  localparam int unsigned PARAMS_W = MCF_PARAMS_SIZE * 8;

  localparam logic [47:0] PAUSE_DST    = 48'h0180C2000001;
  localparam logic [15:0] MAC_CTRL_ETH = 16'h8808;
  localparam logic [15:0] PAUSE_OPCODE = 16'h0001;

  typedef enum logic [1:0] {
    IDLE,
    SEND_XOFF,
    WAIT_REFRESH,
    SEND_XON
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [REFRESH_WIDTH-1:0] refresh_cnt;
  logic [REFRESH_WIDTH-1:0] refresh_cnt_next;
  logic                     handshake;
  logic                     enter_xoff;
  logic                     enter_xon;

  // Fixed PAUSE frame header fields.
  assign mcf_eth_dst  = PAUSE_DST;
  assign mcf_eth_type = MAC_CTRL_ETH;
  assign mcf_opcode   = PAUSE_OPCODE;

  // Next-state and refresh counter logic; release has priority over refresh.
  always_comb begin
    state_next       = state;
    refresh_cnt_next = refresh_cnt;
    handshake        = mcf_valid && mcf_ready;

    case (state)
      IDLE: begin
        if (cfg_enable && xoff_req) begin
          state_next = SEND_XOFF;
        end
      end
      SEND_XOFF: begin
        if (handshake) begin
          state_next       = WAIT_REFRESH;
          refresh_cnt_next = cfg_refresh;
        end
      end
      WAIT_REFRESH: begin
        if (refresh_cnt != '0) begin
          refresh_cnt_next = refresh_cnt - REFRESH_WIDTH'(1);
        end
        if (!xoff_req || !cfg_enable) begin
          state_next = SEND_XON;
        end else if (refresh_cnt == REFRESH_WIDTH'(1) && cfg_refresh != '0) begin
          state_next = SEND_XOFF;
        end
      end
      SEND_XON: begin
        if (handshake) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    enter_xoff = (state != SEND_XOFF) && (state_next == SEND_XOFF);
    enter_xon  = (state != SEND_XON)  && (state_next == SEND_XON);
  end

  // State, frame request and status registers; fields are latched only on
  // entry to a send state so the request stays stable until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      refresh_cnt  <= '0;
      mcf_valid    <= 1'b0;
      mcf_eth_src  <= '0;
      mcf_params   <= '0;
      tx_paused    <= 1'b0;
      stat_tx_xoff <= 1'b0;
      stat_tx_xon  <= 1'b0;
    end else begin
      state        <= state_next;
      refresh_cnt  <= refresh_cnt_next;
      mcf_valid    <= (state_next == SEND_XOFF) || (state_next == SEND_XON);
      stat_tx_xoff <= handshake && (state == SEND_XOFF);
      stat_tx_xon  <= handshake && (state == SEND_XON);

      if (handshake && state == SEND_XOFF) begin
        tx_paused <= 1'b1;
      end else if (handshake && state == SEND_XON) begin
        tx_paused <= 1'b0;
      end

      if (enter_xoff) begin
        mcf_eth_src <= cfg_eth_src;
        mcf_params  <= PARAMS_W'(cfg_quanta);
      end else if (enter_xon) begin
        mcf_eth_src <= cfg_eth_src;
        mcf_params  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mqnic_lfc_tx_ctrl.sv
// Self-checking bench for mqnic_lfc_tx_ctrl: vector table, directed corner
// sequences and randomized traffic against a frame-level reference model.
`timescale 1ns/1ps

module tb_mqnic_lfc_tx_ctrl;

  localparam int unsigned PSIZE = 18;
  localparam int unsigned RW    = 16;
  localparam int unsigned PW    = 144;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_enable;
  logic [47:0]     cfg_eth_src;
  logic [15:0]     cfg_quanta;
  logic [RW-1:0]   cfg_refresh;
  logic            xoff_req;
  logic            mcf_valid;
  logic            mcf_ready;
  logic [47:0]     mcf_eth_dst;
  logic [47:0]     mcf_eth_src;
  logic [15:0]     mcf_eth_type;
  logic [15:0]     mcf_opcode;
  logic [PW-1:0]   mcf_params;
  logic            tx_paused;
  logic            stat_tx_xoff;
  logic            stat_tx_xon;

  int n_chk  = 0;
  int n_fail = 0;

  mqnic_lfc_tx_ctrl #(.MCF_PARAMS_SIZE(PSIZE), .REFRESH_WIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_eth_src(cfg_eth_src),
    .cfg_quanta(cfg_quanta), .cfg_refresh(cfg_refresh),
    .xoff_req(xoff_req),
    .mcf_valid(mcf_valid), .mcf_ready(mcf_ready),
    .mcf_eth_dst(mcf_eth_dst), .mcf_eth_src(mcf_eth_src),
    .mcf_eth_type(mcf_eth_type), .mcf_opcode(mcf_opcode),
    .mcf_params(mcf_params),
    .tx_paused(tx_paused), .stat_tx_xoff(stat_tx_xoff), .stat_tx_xon(stat_tx_xon)
  );

  always #5 clk = ~clk;

  // Reference model: a pending frame (0 none, 1 XOFF, 2 XON) plus whether the
  // partner is believed paused; waiting for refresh/release == paused and nothing pending.
  int          m_pend;
  logic [47:0] m_src;
  logic [15:0] m_q;
  logic        m_paused;
  int          m_timer;
  logic        m_sxoff;
  logic        m_sxon;

  task automatic model_reset();
    m_pend = 0; m_src = '0; m_q = '0; m_paused = 1'b0;
    m_timer = 0; m_sxoff = 1'b0; m_sxon = 1'b0;
  endtask

  task automatic model_step();
    logic accepted;
    accepted = (m_pend != 0) && mcf_ready;
    m_sxoff  = accepted && (m_pend == 1);
    m_sxon   = accepted && (m_pend == 2);
    if (m_pend != 0) begin
      if (accepted) begin
        if (m_pend == 1) begin
          m_paused = 1'b1;
          m_timer  = int'(cfg_refresh);
        end else begin
          m_paused = 1'b0;
        end
        m_pend = 0;
      end
    end else if (m_paused) begin
      if (!xoff_req || !cfg_enable) begin
        m_pend = 2; m_src = cfg_eth_src; m_q = 16'h0;
      end else if (m_timer == 1 && cfg_refresh != '0) begin
        m_pend = 1; m_src = cfg_eth_src; m_q = cfg_quanta;
      end
      if (m_timer > 0) m_timer = m_timer - 1;
    end else if (cfg_enable && xoff_req) begin
      m_pend = 1; m_src = cfg_eth_src; m_q = cfg_quanta;
    end
  endtask

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, PW'(mcf_valid), PW'(m_pend != 0));
    chk({tag, "_paused"}, PW'(tx_paused), PW'(m_paused));
    chk({tag, "_stat_xoff"}, PW'(stat_tx_xoff), PW'(m_sxoff));
    chk({tag, "_stat_xon"}, PW'(stat_tx_xon), PW'(m_sxon));
    if (m_pend != 0) begin
      chk({tag, "_src"}, PW'(mcf_eth_src), PW'(m_src));
      chk({tag, "_params"}, mcf_params, PW'(m_q));
      chk({tag, "_dst"}, PW'(mcf_eth_dst), PW'(48'h0180C2000001));
      chk({tag, "_type"}, PW'(mcf_eth_type), PW'(16'h8808));
      chk({tag, "_opcode"}, PW'(mcf_opcode), PW'(16'h0001));
    end
  endtask

  typedef struct packed {
    logic en, xoff, ready;
    logic e_valid, e_paused, e_sxoff, e_sxon;
  } vec_t;

  vec_t vt [19];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    int          last;
    int          first;
    logic        seen;
    logic [47:0] src_hold;

    rst = 1'b1; cfg_enable = 1'b1; cfg_eth_src = 48'h020000000001;
    cfg_quanta = 16'h00FF; cfg_refresh = RW'(3); xoff_req = 1'b0; mcf_ready = 1'b0;
    model_reset();

    // Reset state
    #1;
    chk("rst_valid_async", PW'(mcf_valid), PW'(0));
    chk("rst_paused_async", PW'(tx_paused), PW'(0));
    chk("rst_params_async", mcf_params, PW'(0));
    do_reset();
    chk("rst_valid", PW'(mcf_valid), PW'(0));
    chk("rst_paused", PW'(tx_paused), PW'(0));
    chk("rst_stats", PW'({stat_tx_xoff, stat_tx_xon}), PW'(0));

    // Vector table: en, xoff, ready -> valid, paused, stat_xoff, stat_xon (refresh = 3)
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 19; i++) begin
      cfg_enable = vt[i].en; xoff_req = vt[i].xoff; mcf_ready = vt[i].ready;
      tick();
      chk($sformatf("vec%0d_valid", i), PW'(mcf_valid), PW'(vt[i].e_valid));
      chk($sformatf("vec%0d_paused", i), PW'(tx_paused), PW'(vt[i].e_paused));
      chk($sformatf("vec%0d_stat_xoff", i), PW'(stat_tx_xoff), PW'(vt[i].e_sxoff));
      chk($sformatf("vec%0d_stat_xon", i), PW'(stat_tx_xon), PW'(vt[i].e_sxon));
    end

    // First frame: request one cycle after xoff_req, accepted immediately
    cfg_enable = 1'b1; cfg_refresh = RW'(0); mcf_ready = 1'b0; xoff_req = 1'b0;
    do_reset();
    cfg_quanta = 16'hFFFF; cfg_eth_src = 48'h0A0B0C0D0E0F; mcf_ready = 1'b1; xoff_req = 1'b1;
    tick();
    chk("first_valid", PW'(mcf_valid), PW'(1));
    chk("first_dst", PW'(mcf_eth_dst), PW'(48'h0180C2000001));
    chk("first_type", PW'(mcf_eth_type), PW'(16'h8808));
    chk("first_opcode", PW'(mcf_opcode), PW'(16'h0001));
    chk("first_params", mcf_params, PW'(16'hFFFF));
    chk("first_src", PW'(mcf_eth_src), PW'(48'h0A0B0C0D0E0F));
    chk("first_paused_early", PW'(tx_paused), PW'(0));
    tick();
    chk("first_stat_xoff", PW'(stat_tx_xoff), PW'(1));
    chk("first_paused", PW'(tx_paused), PW'(1));
    chk("first_valid_drop", PW'(mcf_valid), PW'(0));

    // Refresh every cfg_refresh+1 cycles with ready held high
    cfg_refresh = RW'(10); xoff_req = 1'b0; mcf_ready = 1'b0;
    do_reset();
    xoff_req = 1'b1; mcf_ready = 1'b1;
    cnt = 0; last = -1; first = -1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      tick();
      if (stat_tx_xoff) begin
        cnt = cnt + 1;
        if (last >= 0) chk("refresh_period", PW'(cyc - last), PW'(11));
        else first = cyc;
        last = cyc;
      end
    end
    chk("refresh_first_pulse", PW'(first), PW'(2));
    chk("refresh_xoff_count", PW'(cnt), PW'(4));

    // Release: one XON frame, then idle
    xoff_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (m_pend == 2) seen = 1'b1;
    end
    chk("xon_pending_reached", PW'(seen), PW'(1));
    chk("xon_valid", PW'(mcf_valid), PW'(1));
    chk("xon_params", mcf_params, PW'(0));
    chk("xon_paused_before", PW'(tx_paused), PW'(1));
    tick();
    chk("xon_stat", PW'(stat_tx_xon), PW'(1));
    chk("xon_paused_after", PW'(tx_paused), PW'(0));
    chk("xon_valid_after", PW'(mcf_valid), PW'(0));
    tick();
    chk("xon_idle_valid", PW'(mcf_valid), PW'(0));
    chk("xon_idle_stat", PW'(stat_tx_xon), PW'(0));

    // Back-pressure: frame fields stable while ready low and inputs churn
    cfg_refresh = RW'(0); xoff_req = 1'b0; mcf_ready = 1'b0;
    do_reset();
    cfg_quanta = 16'h1234; cfg_eth_src = 48'h00AA55CC3301; xoff_req = 1'b1;
    tick();
    chk("bp_valid_start", PW'(mcf_valid), PW'(1));
    for (int i = 0; i < 20; i++) begin
      xoff_req = ~xoff_req;
      cfg_quanta = 16'($urandom());
      cfg_eth_src = 48'({$urandom(), $urandom()});
      tick();
      chk($sformatf("bp%0d_valid", i), PW'(mcf_valid), PW'(1));
      chk($sformatf("bp%0d_src", i), PW'(mcf_eth_src), PW'(48'h00AA55CC3301));
      chk($sformatf("bp%0d_params", i), mcf_params, PW'(16'h1234));
    end
    src_hold = cfg_eth_src;
    mcf_ready = 1'b1; xoff_req = 1'b0;
    tick();
    chk("bp_stat_xoff", PW'(stat_tx_xoff), PW'(1));
    chk("bp_paused", PW'(tx_paused), PW'(1));
    tick();
    chk("bp_xon_valid", PW'(mcf_valid), PW'(1));
    chk("bp_xon_params", mcf_params, PW'(0));
    chk("bp_xon_src", PW'(mcf_eth_src), PW'(src_hold));
    tick();
    chk("bp_stat_xon", PW'(stat_tx_xon), PW'(1));
    chk("bp_unpaused", PW'(tx_paused), PW'(0));

    // Refresh disabled: one XOFF only over a long congestion, XON on disable
    cfg_refresh = RW'(0); xoff_req = 1'b0; mcf_ready = 1'b0;
    do_reset();
    xoff_req = 1'b1; mcf_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (stat_tx_xoff) cnt = cnt + 1;
    end
    chk("norefresh_xoff_count", PW'(cnt), PW'(1));
    chk("norefresh_paused", PW'(tx_paused), PW'(1));
    cfg_enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (stat_tx_xon) seen = 1'b1;
    end
    chk("disable_xon_seen", PW'(seen), PW'(1));
    chk("disable_unpaused", PW'(tx_paused), PW'(0));
    cfg_enable = 1'b1;

    // Reset during a pending XON abandons it
    cfg_refresh = RW'(0); xoff_req = 1'b0; mcf_ready = 1'b0;
    do_reset();
    xoff_req = 1'b1; mcf_ready = 1'b1;
    tick();
    tick();
    mcf_ready = 1'b0; xoff_req = 1'b0;
    tick();
    chk("midrst_pre_valid", PW'(mcf_valid), PW'(1));
    chk("midrst_pre_paused", PW'(tx_paused), PW'(1));
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_valid", PW'(mcf_valid), PW'(0));
    chk("midrst_paused", PW'(tx_paused), PW'(0));
    chk("midrst_params", mcf_params, PW'(0));
    @(negedge clk);
    rst = 1'b0; mcf_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mcf_valid) cnt = cnt + 1;
    end
    chk("midrst_no_frame", PW'(cnt), PW'(0));

    // Randomized traffic against the reference model
    cfg_enable = 1'b1; xoff_req = 1'b0; mcf_ready = 1'b0; cfg_refresh = RW'(2);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) xoff_req = ~xoff_req;
      if ($urandom_range(0, 63) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 99) == 0) cfg_refresh = RW'($urandom_range(0, 5));
      mcf_ready   = ($urandom_range(0, 3) != 0);
      cfg_quanta  = 16'($urandom());
      cfg_eth_src = 48'({$urandom(), $urandom()});
      tick();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
